// File: rtl/rca_result_buffer.sv
// rca_result_buffer
// Small first-word-fall-through buffer for {cout,sum} results coming from a
// 3-bit ripple-carry adder. Tracks occupancy as EMPTY/PARTIAL/FULL, flags
// refused pushes with a sticky overflow bit, and can keep a running total of
// accepted results.
//
// Build option: define RESULT_ACCUM_EN to build the 6-bit accumulator on acc.
// Without it, acc is tied to zero and no accumulator flops exist.
//
// DEPTH must be a power of two in 2..8 so the pointers wrap naturally and
// count (0..DEPTH) fits in four bits.

module rca_result_buffer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sum,
  input  logic       cout,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic       clr,
  output logic [3:0] count,
  output logic       overflow,
  output logic [5:0] acc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_CNT = 4'(DEPTH);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_t;

  occ_t             state, next_state;
  logic [3:0]       count_q, next_count;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             overflow_q;
  logic [3:0]       mem [DEPTH];

  logic [3:0]       entry;
  logic             push, pop;
  logic             overflow_set;

  assign entry = {cout, sum};

  // Handshake flags come only from registered occupancy, so in_ready has no
  // combinational dependence on out_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // A push attempt while full is refused and remembered; clr wins over it.
  assign overflow_set = in_valid && (state == FULL) && !clr;

  // Next occupancy: clr empties the buffer, otherwise push/pop adjust count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    next_count = count_q;
    next_state = state;
    if (clr) begin
      next_count = 4'd0;
    end else begin
      unique case ({push, pop})
        2'b10:   next_count = count_q + 4'd1;
        2'b01:   next_count = count_q - 4'd1;
        default: next_count = count_q;
      endcase
    end
    if (next_count == 4'd0) begin
      next_state = EMPTY;
    end else if (next_count == DEPTH_CNT) begin
      next_state = FULL;
    end else begin
      next_state = PARTIAL;
    end
  end

  // Occupancy, pointers and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers see pre-edge values regardless of statement order.
    if (!rst_n) begin
      state      <= EMPTY;
      count_q    <= 4'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state   <= next_state;
      count_q <= next_count;
      if (clr) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (overflow_set) begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  // Entry storage: write the incoming result at the write pointer.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; an entry is only
    // ever read after it was written, and reset/clr simply empty the buffer.
    if (push && !clr) begin
      mem[wr_ptr] <= entry;
    end
  end

  // Head entry falls through combinationally. Gating with out_valid keeps
  // stale storage off the bus, including during reset when count is forced
  // to zero asynchronously.
  assign out_data = out_valid ? mem[rd_ptr] : 4'b0000;

  assign count    = count_q;
  assign overflow = overflow_q;

`ifdef RESULT_ACCUM_EN
  logic [5:0] acc_q;

  // Running total of accepted results, wrapping modulo 64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 6'd0;
    end else if (clr) begin
      acc_q <= 6'd0;
    end else if (push) begin
      acc_q <= acc_q + {2'b00, entry};
    end
  end

  assign acc = acc_q;
`else
  assign acc = 6'd0;
`endif

endmodule
